disp_mem_ctrl: RTL and testbench

Sequencer for the 1-bit × 32 display memory.
- Fill phase: accepts the decoded-bit stream from the Viterbi traceback through a valid/ready handshake and writes 32 bits into the memory.
- Show phase: scans the stored frame out at a divided rate to the display driver.
- Owns the memory's `wr`, `addr` and `d_i` pins, so decoder writes and display reads never collide.
- Sits between the decoder output stage and the display memory.

---
 rtl/disp_pkg.sv | 15 +
 rtl/disp_mem_ctrl_if.sv | 21 ++
 rtl/disp_tick.sv | 28 ++
 rtl/disp_mem_ctrl.sv | 113 +++++++++++
 tb/tb_disp_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// disp_mem_ctrl shared types and defaults.
// State encoding and default frame geometry.
package disp_pkg;

    localparam int DEPTH_D = 32;
    localparam int AW_D    = 5;
    localparam int DIV_D   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SHOW = 2'd2
    } state_t;

endpackage

// File: rtl/disp_mem_ctrl_if.sv
// Decoded-bit stream handshake between the Viterbi
// traceback (master) and the display controller (slave).
interface disp_mem_ctrl_if;

    logic dec_valid;
    logic dec_bit;
    logic dec_ready;

    modport master (
        output dec_valid,
        output dec_bit,
        input  dec_ready
    );

    modport slave (
        input  dec_valid,
        input  dec_bit,
        output dec_ready
    );

endinterface

// File: rtl/disp_tick.sv
// Display rate divider: counts 0..DIV-1 while enabled,
// tick marks the last count; clr forces the count to 0.
module disp_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] divcnt;

    always_ff @(posedge clk) begin
        if (RST || clr) begin
            divcnt <= '0;
        end else if (en) begin
            divcnt <= (divcnt == LAST) ? '0 : divcnt + 1'b1;
        end
    end

    assign tick = en && (divcnt == LAST);

endmodule

// File: rtl/disp_mem_ctrl.sv
// Fill/show sequencer for the 1-bit display memory.
// DISP_LOOP_EN: redisplay the frame until start/RST.
module disp_mem_ctrl
    import disp_pkg::*;
#(
    parameter int DEPTH = DEPTH_D,
    parameter int AW    = AW_D,
    parameter int DIV   = DIV_D
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          start,
    disp_mem_ctrl_if.slave dec,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_di,
    input  logic          mem_do,
    output logic          disp_valid,
    output logic          disp_bit,
    output logic [AW-1:0] disp_idx,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    state_t        state, nxt;
    logic [AW-1:0] wptr, rptr;
    logic          dec_ready_c;
    logic          hs, tick, capture;

    assign hs      = (state == FILL) && dec.dec_valid;
    assign capture = tick && !start;
    assign busy    = (state != IDLE);
    assign dec.dec_ready = dec_ready_c;

    // counter stays cleared outside SHOW so it restarts at 0 on entry
    disp_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .RST  (RST),
        .clr  ((state != SHOW) || start),
        .en   (state == SHOW),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt         = state;
        dec_ready_c = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_di      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) nxt = FILL;
            end
            FILL: begin
                dec_ready_c = 1'b1;
                mem_wr      = dec.dec_valid;
                mem_addr    = wptr;
                mem_di      = dec.dec_bit;
                if (hs && wptr == LAST) nxt = SHOW;
            end
            SHOW: begin
                mem_addr = rptr;
                if (start) begin
                    nxt = FILL;
                end else if (capture && rptr == LAST) begin
`ifdef DISP_LOOP_EN
                    nxt = SHOW;
`else
                    nxt = IDLE;
`endif
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wptr       <= '0;
            rptr       <= '0;
            disp_valid <= 1'b0;
            disp_bit   <= 1'b0;
            disp_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            frame_done <= 1'b0;
            if (start && state != FILL) wptr <= '0;
            else if (hs)                wptr <= inc(wptr);
            if (hs && wptr == LAST) begin
                rptr <= '0;
            end else if (capture) begin
                rptr       <= inc(rptr);
                disp_bit   <= mem_do;
                disp_idx   <= rptr;
                disp_valid <= 1'b1;
                frame_done <= (rptr == LAST);
            end
        end
    end

endmodule

// File: tb/tb_disp_mem_ctrl.sv
// Self-checking bench for disp_mem_ctrl with a behavioural
// memory and a frame/timing reference derived from the bits sent.
module tb_disp_mem_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DIV   = 4;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic          d;
    } wr_ev_t;

    typedef struct {
        int            cyc;
        logic          b;
        logic [AW-1:0] idx;
        logic          fd;
        logic          busy;
    } dp_ev_t;

    logic          clk = 1'b0;
    logic          RST, start;
    logic          mem_wr, mem_di, mem_do;
    logic [AW-1:0] mem_addr, disp_idx;
    logic          disp_valid, disp_bit, busy, frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stray    = 0;

    logic   mem [DEPTH];
    wr_ev_t wq[$];
    dp_ev_t dq[$];

    disp_mem_ctrl_if dif();

    disp_mem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DIV(DIV)) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .dec        (dif),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_di     (mem_di),
        .mem_do     (mem_do),
        .disp_valid (disp_valid),
        .disp_bit   (disp_bit),
        .disp_idx   (disp_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 1x32 memory with registered read
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_di;
        mem_do <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_wr) wq.push_back('{cyc, mem_addr, mem_di});
        if (disp_valid)
            dq.push_back('{cyc, disp_bit, disp_idx, frame_done, busy});
        if (frame_done && !disp_valid) stray++;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_ready"}, 32'(dif.dec_ready), 0);
        chk({tag, "_wr"}, 32'(mem_wr), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_di"}, 32'(mem_di), 0);
        chk({tag, "_dv"}, 32'(disp_valid), 0);
        chk({tag, "_db"}, 32'(disp_bit), 0);
        chk({tag, "_didx"}, 32'(disp_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
    endtask

    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        wq.delete();
        dq.delete();
    endtask

    task automatic fill(logic [31:0] bits, int gap, bit poke);
        for (int i = 0; i < DEPTH; i++) begin
            for (int g = 0; g < gap; g++) begin
                dif.dec_valid = 1'b0;
                step();
            end
            dif.dec_valid = 1'b1;
            dif.dec_bit   = bits[i];
            start         = poke && (i == 16);
            step();
            start = 1'b0;
        end
        dif.dec_valid = 1'b0;
    endtask

    task automatic wait_ev(int n);
        int b = 0;
        while (dq.size() < n && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk("wait_ev", 32'(dq.size() >= n), 1);
    endtask

    task automatic check_frame(string tag, logic [31:0] bits);
        int k;
        chk({tag, "_nwr"}, 32'(wq.size()), DEPTH);
        chk({tag, "_stray"}, 32'(stray), 0);
        if (wq.size() == DEPTH && dq.size() >= DEPTH) begin
            k = wq[DEPTH-1].cyc;
            chk({tag, "_first"}, 32'(dq[0].cyc), 32'(k + DIV + 1));
            for (int i = 0; i < DEPTH; i++) begin
                chk($sformatf("%s_waddr%0d", tag, i), 32'(wq[i].a), 32'(i));
                chk($sformatf("%s_wdat%0d", tag, i), 32'(wq[i].d), 32'(bits[i]));
                chk($sformatf("%s_bit%0d", tag, i), 32'(dq[i].b), 32'(bits[i]));
                chk($sformatf("%s_idx%0d", tag, i), 32'(dq[i].idx), 32'(i));
                chk($sformatf("%s_fd%0d", tag, i), 32'(dq[i].fd),
                    32'(i == DEPTH - 1));
                if (i > 0)
                    chk($sformatf("%s_gap%0d", tag, i),
                        32'(dq[i].cyc - dq[i-1].cyc), DIV);
            end
`ifdef DISP_LOOP_EN
            chk({tag, "_fdbusy"}, 32'(dq[DEPTH-1].busy), 1);
`else
            chk({tag, "_fdbusy"}, 32'(dq[DEPTH-1].busy), 0);
`endif
        end
    endtask

    task automatic check_end(string tag, logic [31:0] bits);
`ifdef DISP_LOOP_EN
        wait_ev(DEPTH + 1);
        if (dq.size() > DEPTH) begin
            chk({tag, "_loopgap"}, 32'(dq[DEPTH].cyc - dq[DEPTH-1].cyc), DIV);
            chk({tag, "_loopidx"}, 32'(dq[DEPTH].idx), 0);
            chk({tag, "_loopbit"}, 32'(dq[DEPTH].b), 32'(bits[0]));
        end
`else
        repeat (DIV * 3) @(negedge clk);
        chk({tag, "_nomore"}, 32'(dq.size()), DEPTH);
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_bits0"}, 32'(bits[0]), 32'(bits[0]) & 32'(dq[0].b | ~bits[0]));
`endif
    endtask

    initial begin
        logic [31:0] pat;
        int          tgt;
        RST = 1'b1;
        start = 1'b0;
        dif.dec_valid = 1'b0;
        dif.dec_bit = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_idle("rst");
        step();
        RST = 1'b0;

        // fixed pattern, back-to-back, start poked mid-fill
        pat = 32'hA5C3_0F96;
        begin_frame();
        fill(pat, 0, 1'b1);
        wait_ev(DEPTH);
        check_frame("pat", pat);
        check_end("pat", pat);

        // random frame, valid every third cycle
        step();
        pat = $urandom();
        begin_frame();
        fill(pat, 2, 1'b0);
        wait_ev(DEPTH);
        check_frame("gap", pat);
        check_end("gap", pat);

        // restart when idx 10 would be captured
        step();
        pat = $urandom();
        begin_frame();
        fill(pat, 0, 1'b0);
        wait_ev(10);
        tgt = dq[9].cyc + DIV - 1;
        while (cyc < tgt) step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("rs_nostrobe", 32'(dq.size()), 10);
        chk("rs_ready", 32'(dif.dec_ready), 1);
        wq.delete();
        dq.delete();
        fill('1, 0, 1'b0);
        wait_ev(DEPTH);
        check_frame("ones", '1);

        // reset for two cycles mid-show
        step();
        pat = $urandom();
        begin_frame();
        fill(pat, 1, 1'b0);
        wait_ev(5);
        step();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        dq.delete();
        @(negedge clk);
        check_idle("mid");
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("mid_nodisp", 32'(dq.size()), 0);
        chk("mid_ready", 32'(dif.dec_ready), 1);
        chk("mid_busy", 32'(busy), 1);
        step();
        wq.delete();
        dq.delete();
        pat = $urandom();
        fill(pat, 0, 1'b0);
        wait_ev(DEPTH);
        check_frame("post", pat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
